// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : mult_seq_pkg                                         |
// | Description : Shared types and constants for the iterative         |
// |               multiplier sequencer: FSM state encoding and the     |
// |               opcode set of the shared datapath ALU.               |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package mult_seq_pkg;

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes understood by the shared datapath ALU
  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_NOR  = 4'b0010;
  localparam logic [3:0] c_ALU_ADD  = 4'b0011;
  localparam logic [3:0] c_ALU_SLL  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_ADDI = 4'b0110;
  localparam logic [3:0] c_ALU_ORI  = 4'b0111;
  localparam logic [3:0] c_ALU_LUI  = 4'b1000;
  localparam logic [3:0] c_ALU_ANDI = 4'b1001;

  // Default operand width; one shift-add iteration per multiplier bit
  localparam int c_WIDTH      = 32;
  localparam int c_ITERATIONS = c_WIDTH;

endpackage
`default_nettype wire

// File: rtl/mult_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface   : mult_sequencer_if                                    |
// | Description : Control/datapath <-> multiplier sequencer bundle,    |
// |               including the ALU request path the sequencer muxes.  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface mult_sequencer_if #(
  parameter int WIDTH = 32
) ();
  import mult_seq_pkg::*;

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       dp_alu_op;
  logic [WIDTH-1:0] dp_alu_a;
  logic [WIDTH-1:0] dp_alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Control/datapath side (and the ALU returning its result)
  modport master (
    output start, signed_op, a_in, b_in, dp_alu_op, dp_alu_a, dp_alu_b, alu_result,
    input  alu_op, alu_a, alu_b, busy, stall, done, hi, lo
  );

  // Sequencer side
  modport slave (
    input  start, signed_op, a_in, b_in, dp_alu_op, dp_alu_a, dp_alu_b, alu_result,
    output alu_op, alu_a, alu_b, busy, stall, done, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mult_sequencer_alu_owner_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : alu_owner_mux                                        |
// | Description : 2:1 selector of ALU {op,a,b} between the datapath    |
// |               and a client that has taken ownership of the ALU.    |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module alu_owner_mux #(
  parameter int WIDTH = 32
) (
  input  wire logic             i_sel_owner,
  input  wire logic [3:0]       i_own_op,
  input  wire logic [WIDTH-1:0] i_own_a,
  input  wire logic [WIDTH-1:0] i_own_b,
  input  wire logic [3:0]       i_dp_op,
  input  wire logic [WIDTH-1:0] i_dp_a,
  input  wire logic [WIDTH-1:0] i_dp_b,
  output logic      [3:0]       o_op,
  output logic      [WIDTH-1:0] o_a,
  output logic      [WIDTH-1:0] o_b
);

  // Owner request wins while it holds the ALU, datapath otherwise
  assign o_op = i_sel_owner ? i_own_op : i_dp_op;
  assign o_a  = i_sel_owner ? i_own_a  : i_dp_a;
  assign o_b  = i_sel_owner ? i_own_b  : i_dp_b;

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mult_sequencer                                       |
// | Description : Iterative WIDTHxWIDTH unsigned shift-add multiplier  |
// |               that borrows the shared ALU for its partial sums.    |
// |               Optional macro SIGNED_MULT_EN adds sign-magnitude    |
// |               signed multiply with a final 2*WIDTH negate state.   |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] ALU_ADD_OP = c_ALU_ADD
) (
  input wire logic         clk,
  input wire logic         reset,
  mult_sequencer_if.slave  bus
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_stall;
  logic             r_done;

  logic             w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_a_op;
  logic [WIDTH-1:0] w_b_op;
  state_t           w_after_iter;

  // The ALU only sees hi+mcand, so a wrapped sum is the carry-out
  assign w_carry = r_lo[0] & (bus.alu_result < r_hi);
  assign w_sum   = r_lo[0] ? bus.alu_result : r_hi;

`ifdef SIGNED_MULT_EN
  logic                 r_neg;
  logic                 w_neg_flag;
  logic [2*WIDTH-1:0]   w_prod_neg;

  // Signed requests iterate on magnitudes; the most negative value maps to itself
  assign w_a_op       = (bus.signed_op && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign w_b_op       = (bus.signed_op && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
  assign w_neg_flag   = bus.signed_op & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
  assign w_prod_neg   = -{r_hi, r_lo};
  assign w_after_iter = r_neg ? ST_NEG : ST_DONE;
`else
  logic w_unused_signed_op;

  assign w_a_op             = bus.a_in;
  assign w_b_op             = bus.b_in;
  assign w_after_iter       = ST_DONE;
  assign w_unused_signed_op = bus.signed_op;
`endif

  // Sequencer FSM: operand capture, shift-add iterations, optional negate, done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
`ifdef SIGNED_MULT_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mcand <= w_a_op;
            r_lo    <= w_b_op;
            r_hi    <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_stall <= 1'b1;
            r_state <= ST_ITER;
`ifdef SIGNED_MULT_EN
            r_neg   <= w_neg_flag;
`endif
          end
        end
        ST_ITER: begin
          {r_hi, r_lo} <= {w_carry, w_sum, r_lo[WIDTH-1:1]};
          r_count      <= r_count + 1'b1;
          if (r_count == c_LAST) begin
            r_state <= w_after_iter;
            if (w_after_iter == ST_DONE) begin
              r_stall <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
`ifdef SIGNED_MULT_EN
        ST_NEG: begin
          {r_hi, r_lo} <= w_prod_neg;
          r_stall      <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= ST_DONE;
        end
`endif
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  alu_owner_mux #(
    .WIDTH (WIDTH)
  ) u_alu_owner_mux (
    .i_sel_owner (r_stall),
    .i_own_op    (ALU_ADD_OP),
    .i_own_a     (r_hi),
    .i_own_b     (r_mcand),
    .i_dp_op     (bus.dp_alu_op),
    .i_dp_a      (bus.dp_alu_a),
    .i_dp_b      (bus.dp_alu_b),
    .o_op        (bus.alu_op),
    .o_a         (bus.alu_a),
    .o_b         (bus.alu_b)
  );

  assign bus.busy  = r_busy;
  assign bus.stall = r_stall;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mult_sequencer                                    |
// | Description : Directed self-checking bench for mult_sequencer with |
// |               a behavioural shared ALU. Honours SIGNED_MULT_EN.    |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_mult_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(
    .WIDTH      (32),
    .ALU_ADD_OP (4'b0011)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model: ADD, otherwise bitwise OR
  assign bus.alu_result = (bus.alu_op == 4'b0011) ? (bus.alu_a + bus.alu_b)
                                                  : (bus.alu_a | bus.alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] eh, input logic [31:0] el,
                          input int elat);
    int   lat;
    logic ok;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.signed_op = sg;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    ok  = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1 || bus.alu_op !== 4'b0011) ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, eh});
    check({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, el});
    check({tag, "_stall_addop"}, {63'h0, ok}, 64'h1);
    tick();
    check({tag, "_done_pulse"}, {63'h0, bus.done}, 64'h0);
    check({tag, "_idle"}, {63'h0, bus.busy}, 64'h0);
    bus.signed_op = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, nd;
    logic [63:0] r1, r2;

    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.dp_alu_op = '0;
    bus.dp_alu_a  = '0;
    bus.dp_alu_b  = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy",  {63'h0, bus.busy},  64'h0);
    check("rst_stall", {63'h0, bus.stall}, 64'h0);
    check("rst_done",  {63'h0, bus.done},  64'h0);
    check("rst_hilo",  {bus.hi, bus.lo},   64'h0);

    // IDLE pass-through, same cycle
    bus.dp_alu_op = 4'b0001;
    bus.dp_alu_a  = 32'hF0F0_0000;
    bus.dp_alu_b  = 32'h0000_0F0F;
    #1;
    check("pt_op",    {60'h0, bus.alu_op}, 64'h1);
    check("pt_a",     {32'h0, bus.alu_a},  64'hF0F0_0000);
    check("pt_b",     {32'h0, bus.alu_b},  64'h0000_0F0F);
    check("pt_stall", {63'h0, bus.stall},  64'h0);

    // Unsigned products
    run_mult("m7x6",  32'd7,          32'd6,          1'b0, 32'h0,         32'd42,        32);
    run_mult("mFxF",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    run_mult("m16sq", 32'h0001_0000,  32'h0001_0000,  1'b0, 32'h1,         32'h0,         32);
    run_mult("mMSBx3",32'h8000_0000,  32'd3,          1'b0, 32'h1,         32'h8000_0000, 32);

    // Start held high through busy with a new operand pair loaded
    bus.a_in  = 32'd7;
    bus.b_in  = 32'd6;
    bus.start = 1'b1;
    tick();
    bus.a_in = 32'd3;
    bus.b_in = 32'd5;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int i = 1; i <= 66; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        if (i <= 33) begin d1++; r1 = {bus.hi, bus.lo}; end
        else begin d2++; r2 = {bus.hi, bus.lo}; end
      end
    end
    bus.start = 1'b0;
    check("hold_done_cnt1", 64'(d1), 64'd1);
    check("hold_result1",   r1,      64'd42);
    check("hold_done_cnt2", 64'(d2), 64'd1);
    check("hold_result2",   r2,      64'd15);
    tick();
    tick();
    check("hold_idle", {63'h0, bus.busy}, 64'h0);

    // Reset at iteration 10 aborts cleanly
    bus.a_in  = 32'd7;
    bus.b_in  = 32'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",  {63'h0, bus.busy},  64'h0);
    check("abort_stall", {63'h0, bus.stall}, 64'h0);
    check("abort_hilo",  {bus.hi, bus.lo},   64'h0);
    nd = 0;
    for (int i = 0; i < 35; i++) begin
      if (bus.done === 1'b1) nd++;
      tick();
    end
    check("abort_no_done", 64'(nd), 64'd0);
    run_mult("post_abort", 32'd5, 32'd9, 1'b0, 32'h0, 32'd45, 32);

    // Signed request: -3 * 5
`ifdef SIGNED_MULT_EN
    run_mult("sgn_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_mult("sgn_off",  32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1, 32);
`else
    run_mult("sgn_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, 32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Iterative 32x32 unsigned multiplier (MULTU) that produces a 64-bit HI/LO result in 32 iterations.
- Has no adder of its own: each iteration borrows the shared datapath ALU through its ADD operation.
- Sits between the control/datapath and the ALU. It owns the ALU input mux, stalls the pipeline while it holds the ALU, and hands the ALU back when finished.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH.
- ALU_ADD_OP, 4'b0011: ALUOperation code driven for the partial-sum add.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- signed_op  in  1  signed multiply request; used only with SIGNED_MULT_EN.
- a_in  in  WIDTH  multiplicand (rs), captured on accepted start.
- b_in  in  WIDTH  multiplier (rt), captured on accepted start.
- dp_alu_op  in  4  datapath-requested ALUOperation.
- dp_alu_a  in  WIDTH  datapath-requested ALU operand A.
- dp_alu_b  in  WIDTH  datapath-requested ALU operand B.
- alu_result  in  WIDTH  ALUResult returned from the shared ALU.
- alu_op  out  4  to ALU ALUOperation.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- busy  out  1  state != IDLE.
- stall  out  1  high while the sequencer owns the ALU (state ITER/NEG).
- done  out  1  one-cycle pulse; hi/lo are final.
- hi  out  WIDTH  upper product half.
- lo  out  WIDTH  lower product half.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high. On reset: state=IDLE, hi=0, lo=0, mcand=0, count=0, done=0, busy=0, stall=0. Reset mid-operation aborts with the same values on the next edge.
- States: IDLE, ITER, [NEG], DONE.
- IDLE:
  - ALU pass-through: alu_op/alu_a/alu_b = dp_alu_op/dp_alu_a/dp_alu_b.
  - start=1 at edge E0 -> mcand=a_in, lo=b_in, hi=0, count=0, state=ITER.
- ITER, edges E1..E32:
  - Drives alu_op=ALU_ADD_OP, alu_a=hi, alu_b=mcand.
  - carry = lo[0] & (alu_result < hi), unsigned compare, i.e. wrap detection.
  - sum = lo[0] ? alu_result : hi.
  - {hi,lo} <= {carry, sum, lo[WIDTH-1:1]}.
  - count <= count+1. At count==WIDTH-1 go to DONE (or NEG, see option).
- DONE: done=1 for exactly one cycle (after E32), then IDLE at E33. ALU is already in pass-through in DONE.
- Latency: start edge to done-high = 32 cycles unsigned. hi/lo hold their value until the next accepted start.
- start while busy: ignored, no queueing.
- start in IDLE with done: impossible; done is only asserted in DONE.
- Combinational path: alu_result to {hi,lo} next state only. No path from alu_result to any output in the same cycle.
- count width = $clog2(WIDTH); must not wrap before transition.

Optional Feature:
- Macro: SIGNED_MULT_EN.
- Defined:
  - On accepted start with signed_op=1: operands replaced by their magnitudes (two's-complement negate if MSB set; 0x80000000 magnitude is 0x80000000 unsigned), and neg_flag = a_in[31]^b_in[31] is latched.
  - After ITER, if neg_flag: NEG state for one cycle, {hi,lo} <= -{hi,lo} (internal 64-bit negate, ALU not used, stall still 1), then DONE. Latency is 33 cycles.
  - signed_op=0 behaves as unsigned.
- Undefined: signed_op ignored, no NEG state, neg_flag logic absent.

Decomposition:
- Package mult_seq_pkg holds:
  - state encoding localparams (IDLE, ITER, NEG, DONE);
  - ALU opcode constants mirroring the ALU (AND 0000, OR 0001, NOR 0010, ADD 0011, SLL 0100, SRL 0101, ADDI 0110, ORI 0111, LUI 1000, ANDI 1001);
  - ITERATIONS = WIDTH.
- One sub-module, alu_owner_mux: a pure 2:1 mux of {op,a,b} selected by the sequencer-owns signal. Reusable when other ALU clients are added.

Test Plan:
- IDLE pass-through: dp_alu_op=4'b0001, dp_alu_a=0xF0F0_0000, dp_alu_b=0x0000_0F0F -> alu_op/alu_a/alu_b identical same cycle; stall=0.
- a_in=7, b_in=6, start one cycle -> stall=1 for 32 cycles, alu_op=4'b0011 throughout; done pulse 32 cycles after start; hi=0, lo=42.
- a_in=b_in=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 (exercises carry every iteration).
- Start held high through busy, with a second pair of operands -> exactly one done per 33-cycle window; first result unaffected.
- Reset asserted at iteration 10 -> next edge busy=0, stall=0, hi=lo=0; no done; new start works normally.
- SIGNED_MULT_EN, signed_op=1, a_in=0xFFFF_FFFD (-3), b_in=5 -> done 33 cycles after start, hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. Without the macro, the same stimulus gives the unsigned product (hi=0x0000_0004, lo=0xFFFF_FFF1) in 32 cycles.
